systolic_row_feeder: RTL
========================

// Module: systolic_row_feeder
// PURPOSE
//  Transmit side of the Systolic_pe_v1 array row interface. Loads one weight tile, then broadcasts it to all PEs with a single weight_valid pulse.
//  Streams activation vectors into the array's west edge, skewed so row r lags row 0 by r cycles; the skew is generated in hardware, not by software or the bench.
//  Sits between the activation/weight buffers and the PE grid.
// PARAMETERS
//  ROWS      2                     array rows = activation lanes
//  COLS      2                     array columns; weight tile is ROWS*COLS words
//  DW        `SYSTOLIC_DATA_WIDTH  activation/weight word width
//  VEC_LEN   16                    activation vectors per tile (>=1)
// PORTS
//  s_clk           in   1             clock; all logic on rising edge
//  s_rst           in   1             reset, asynchronous, active-low
//  tile_start      in   1             start a tile; sampled in IDLE only
//  tile_load_w     in   1             with tile_start: 1 = load new weights, 0 = reuse held weights
//  tile_busy       out  1             high from tile accept until done
//  tile_done       out  1             one-cycle pulse when the last row drains
//  w_in_valid      in   1             weight word valid
//  w_in_data       in   DW            weight word; k-th word -> PE(k/COLS, k%COLS)
//  w_in_ready      out  1             high only in LOAD_W
//  act_in_valid    in   1             activation vector valid
//  act_in_data     in   ROWS*DW       lane r at [r*DW +: DW]
//  act_in_ready    out  1             high only in STREAM
//  pe_weight_valid out  1             one-cycle broadcast pulse to all PEs
//  pe_weights      out  ROWS*COLS*DW  PE(r,c) at [(r*COLS+c)*DW +: DW]; held stable between loads
//  pe_data_valid   out  ROWS          per-row west-edge valid
//  pe_raw_data     out  ROWS*DW       per-row west-edge data
// BEHAVIOUR
//  - Reset (async, s_rst=0): every output 0, pe_weights 0, delay lines cleared, FSM to IDLE.
//  - Handshake: a transfer happens when valid & ready at a rising edge. Upstream must hold data while ready=0.
//  - FSM states: IDLE, LOAD_W, STREAM, DRAIN.
//    IDLE: on tile_start, go to LOAD_W if tile_load_w=1, else STREAM. tile_busy=1 from the next cycle.
//    LOAD_W: count weight transfers. On transfer number ROWS*COLS, write the word, go to STREAM, and pulse pe_weight_valid in the next cycle.
//    STREAM: count activation transfers. On transfer number VEC_LEN, go to DRAIN.
//    DRAIN: stay ROWS cycles, then go to IDLE with tile_done=1 and tile_busy=0 in the same cycle.
//  - Weight capture: words are written into a shadow register in arrival order; the shadow is copied to pe_weights on the pulse.
//  - Latency and skew: a vector transferred in cycle t drives pe_data_valid[r]=1 and lane r data in cycle t+1+r.
//  - Delay lines: shift every cycle regardless of FSM state, carrying (valid,data) pairs.
//    Cycles with no transfer inject valid=0 and data=0, so bubbles keep the skew on every row.
//  - Last row output appears at t_last+ROWS; tile_done pulses at t_last+ROWS+1.
//  - Ignored inputs: tile_start outside IDLE. w_in_valid outside LOAD_W (ready=0). act_in_valid outside STREAM.
//  - No backpressure from the array: once accepted, a vector always drains.
//  - Reset mid-tile: pending skewed data is discarded; the next tile starts clean.
// STRUCTURE
//  - Shared package/header (hyper_para): SYSTOLIC_DATA_WIDTH, SYSTOLIC_ROWS, SYSTOLIC_COLS, state encodings.
//  - Sub-module skew_delay_line #(DEPTH, DW): DEPTH-stage (valid,data) shift register with async active-low clear.
//    Instantiated per row with DEPTH=r+1. Row 0 is DEPTH=1, which is the output register.
//  - The top level holds the FSM, weight/vector counters, the weight shadow and the pulse logic.
// TESTING (ROWS=COLS=2, VEC_LEN=2 unless noted)
//  1. Start with tile_load_w=1, send weights 1,2,3,4 back-to-back.
//     -> pe_weight_valid high exactly 1 cycle, the cycle after word 4; pe_weights = {4,3,2,1} (PE00 LSB); w_in_ready low after.
//  2. Send vectors {r0=1,r1=2} at t and {5,6} at t+1.
//     -> row0 valid at t+1,t+2 with data 1,5; row1 valid at t+2,t+3 with data 2,6; tile_done at t+4.
//  3. Same as 2 with act_in_valid low in cycle t+1 (second vector sent at t+2).
//     -> row0 valid t+1,t+3; row1 valid t+2,t+4; invalid slots carry data 0.
//  4. Start with tile_load_w=0.
//     -> FSM enters STREAM directly; w_in_ready stays 0; no pe_weight_valid; pe_weights keep the previous values.
//  5. Pull s_rst low after the first vector is accepted.
//     -> all outputs 0 immediately, tile_busy=0. A following tile then reproduces test 2 exactly.
//  6. Pulse tile_start during STREAM; set VEC_LEN=1.
//     -> no restart, vector count unaffected; exactly one tile_done per accepted tile.

Source files
------------

// File: rtl/systolic_row_feeder_pkg.sv
// Shared sizing defaults and FSM state encoding for the systolic array row feeder.
package systolic_row_feeder_pkg;

  localparam int SYSTOLIC_DATA_WIDTH = 8;
  localparam int SYSTOLIC_ROWS       = 2;
  localparam int SYSTOLIC_COLS       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage (valid,data) shift register; one instance per array row sets that row's skew.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic [DEPTH-1:0]         r_vld;
  logic [DEPTH-1:0][DW-1:0] r_dat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      r_dat <= '0;
    end else begin
      r_vld[0] <= i_valid;
      r_dat[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_data  = r_dat[DEPTH-1];

endmodule

// File: rtl/systolic_row_feeder.sv
// Row-side feeder for the systolic PE grid: loads/broadcasts a weight tile and
// streams activation vectors into the west edge with per-row hardware skew.
module systolic_row_feeder
  import systolic_row_feeder_pkg::*;
#(
  parameter int ROWS    = SYSTOLIC_ROWS,
  parameter int COLS    = SYSTOLIC_COLS,
  parameter int DW      = SYSTOLIC_DATA_WIDTH,
  parameter int VEC_LEN = 16
) (
  input  logic                   s_clk,
  input  logic                   s_rst,
  input  logic                   tile_start,
  input  logic                   tile_load_w,
  output logic                   tile_busy,
  output logic                   tile_done,
  input  logic                   w_in_valid,
  input  logic [DW-1:0]          w_in_data,
  output logic                   w_in_ready,
  input  logic                   act_in_valid,
  input  logic [ROWS*DW-1:0]     act_in_data,
  output logic                   act_in_ready,
  output logic                   pe_weight_valid,
  output logic [ROWS*COLS*DW-1:0] pe_weights,
  output logic [ROWS-1:0]        pe_data_valid,
  output logic [ROWS*DW-1:0]     pe_raw_data
);

  localparam int NW  = ROWS * COLS;
  localparam int WCW = $clog2(NW + 1);
  localparam int VCW = $clog2(VEC_LEN + 1);
  localparam int DCW = $clog2(ROWS + 1);

  feeder_state_e r_state, w_state_nxt;

  logic [WCW-1:0]     r_w_cnt;
  logic [VCW-1:0]     r_v_cnt;
  logic [DCW-1:0]     r_d_cnt;
  logic [NW*DW-1:0]   r_w_shadow, w_shadow_nxt, r_pe_weights;
  logic               r_pe_wvld, r_tile_done;
  logic               w_w_fire, w_a_fire, w_w_last, w_a_last, w_d_last;
  logic [ROWS*DW-1:0] w_inj_data;

  assign w_w_fire = w_in_valid & w_in_ready;
  assign w_a_fire = act_in_valid & act_in_ready;
  assign w_w_last = (r_w_cnt == WCW'(NW - 1));
  assign w_a_last = (r_v_cnt == VCW'(VEC_LEN - 1));
  assign w_d_last = (r_d_cnt == DCW'(ROWS - 1));

  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    tile_busy    = (r_state != ST_IDLE);
    w_in_ready   = 1'b0;
    act_in_ready = 1'b0;
    case (r_state)
      ST_IDLE:   if (tile_start) w_state_nxt = tile_load_w ? ST_LOAD_W : ST_STREAM;
      ST_LOAD_W: begin
        w_in_ready = 1'b1;
        if (w_w_fire && w_w_last) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        act_in_ready = 1'b1;
        if (w_a_fire && w_a_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN:  if (w_d_last) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Final word is merged in so pe_weights is already complete in the pulse cycle.
  always_comb begin
    w_shadow_nxt = r_w_shadow;
    for (int k = 0; k < NW; k++) begin
      if (r_w_cnt == WCW'(k)) w_shadow_nxt[k*DW +: DW] = w_in_data;
    end
  end

  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_w_cnt      <= '0;
      r_v_cnt      <= '0;
      r_d_cnt      <= '0;
      r_w_shadow   <= '0;
      r_pe_weights <= '0;
      r_pe_wvld    <= 1'b0;
      r_tile_done  <= 1'b0;
    end else begin
      r_pe_wvld   <= w_w_fire & w_w_last;
      r_tile_done <= (r_state == ST_DRAIN) & w_d_last;
      if (r_state == ST_IDLE) begin
        r_w_cnt <= '0;
        r_v_cnt <= '0;
        r_d_cnt <= '0;
      end else begin
        if (w_w_fire) r_w_cnt <= r_w_cnt + 1'b1;
        if (w_a_fire) r_v_cnt <= r_v_cnt + 1'b1;
        if (r_state == ST_DRAIN) r_d_cnt <= r_d_cnt + 1'b1;
      end
      if (w_w_fire) r_w_shadow <= w_shadow_nxt;
      if (w_w_fire && w_w_last) r_pe_weights <= w_shadow_nxt;
    end
  end

  assign pe_weight_valid = r_pe_wvld;
  assign pe_weights      = r_pe_weights;
  assign tile_done       = r_tile_done;

  // Non-transfer cycles inject zero data so bubbles keep every row's skew.
  assign w_inj_data = w_a_fire ? act_in_data : '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_delay_line #(
      .DEPTH (r + 1),
      .DW    (DW)
    ) u_skew (
      .i_clk   (s_clk),
      .i_rst_n (s_rst),
      .i_valid (w_a_fire),
      .i_data  (w_inj_data[r*DW +: DW]),
      .o_valid (pe_data_valid[r]),
      .o_data  (pe_raw_data[r*DW +: DW])
    );
  end

endmodule
